// File: rtl/interp_pkg.sv
// Shared types and constants for the polyphase interpolation filter.
// Default taps give linear interpolation for an upsampling ratio of 2 with 2 taps per phase.
package interp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    HOLD
  } state_t;

  localparam logic signed [9:0] INTERP_COEFFS_DEFAULT [4] = '{10'sd128, 10'sd256, 10'sd128, 10'sd0};

endpackage

// File: rtl/interp_coeff_rom.sv
// Combinational coefficient lookup for the polyphase filter.
// Tap j of phase k reads prototype coefficient h[j*Factor + k].
module interp_coeff_rom
  import interp_pkg::*;
#(
  parameter int Factor = 2,
  parameter int TapsPerPhase = 2,
  parameter int Coeff_bits = 10,
  parameter logic signed [Coeff_bits-1:0] Coeffs [Factor*TapsPerPhase] = INTERP_COEFFS_DEFAULT,
  localparam int TapW = (TapsPerPhase > 1) ? $clog2(TapsPerPhase) : 1,
  localparam int PhW = $clog2(Factor)
) (
  input  logic [TapW-1:0]              tap,
  input  logic [PhW-1:0]               phase,
  output logic signed [Coeff_bits-1:0] coeff
);

  localparam int Depth = Factor * TapsPerPhase;
  localparam int AddrW = $clog2(Depth);

  logic [AddrW-1:0] addr;

  assign addr  = AddrW'(tap) * AddrW'(Factor) + AddrW'(phase);
  assign coeff = Coeffs[addr];

endmodule

// File: rtl/interp_filter.sv
// Polyphase interpolating FIR: each accepted sample yields Factor outputs, each
// computed with one time-shared signed MAC over a circular history of TapsPerPhase samples.
module interp_filter
  import interp_pkg::*;
#(
  parameter int Factor = 2,
  parameter int TapsPerPhase = 2,
  parameter int Data_bits = 10,
  parameter int Coeff_bits = 10,
  parameter logic signed [Coeff_bits-1:0] Coeffs [Factor*TapsPerPhase] = INTERP_COEFFS_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic signed [Data_bits-1:0] in_data_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic signed [Data_bits-1:0] out_data_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i
);

  localparam int PtrW = (TapsPerPhase > 1) ? $clog2(TapsPerPhase) : 1;
  localparam int PhW = $clog2(Factor);
  localparam int AccW = Data_bits + Coeff_bits + $clog2(TapsPerPhase + 1);
  localparam int ProdW = Data_bits + Coeff_bits;
  localparam int Shift = Coeff_bits - 2;
  localparam logic [PtrW-1:0] LastTap = PtrW'(TapsPerPhase - 1);
  localparam logic [PhW-1:0] LastPhase = PhW'(Factor - 1);

  state_t state_reg, state_next;
  logic [PtrW-1:0] wr_ptr_reg, tap_reg, rd_idx;
  logic [PhW-1:0] phase_reg;
  logic signed [AccW-1:0] acc_reg, acc_sum, acc_shifted;
  logic signed [Data_bits-1:0] hist [TapsPerPhase];
  logic signed [Data_bits-1:0] sample, sat_data, out_data_reg;
  logic signed [Coeff_bits-1:0] coeff;
  logic signed [ProdW-1:0] product;
  logic out_valid_reg;
  logic accept, out_fire, last_tap, fits;

  assign in_ready_o  = (state_reg == IDLE) && !rst_i;
  assign accept      = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_reg && out_ready_i;
  assign last_tap    = (tap_reg == LastTap);
  assign out_data_o  = out_data_reg;
  assign out_valid_o = out_valid_reg;

  // One register per history slot; only the slot under the write pointer loads.
  for (genvar gi = 0; gi < TapsPerPhase; gi++) begin : g_hist
    logic signed [Data_bits-1:0] entry_reg;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        entry_reg <= '0;
      end else if (accept && (wr_ptr_reg == PtrW'(gi))) begin
        entry_reg <= in_data_i;
      end
    end
    assign hist[gi] = entry_reg;
  end

  // Newest sample sits just behind the write pointer; tap j walks further back.
  always_comb begin
    int idx;
    idx = int'(wr_ptr_reg) + TapsPerPhase - 1 - int'(tap_reg);
    if (idx >= TapsPerPhase) idx = idx - TapsPerPhase;
    rd_idx = PtrW'(idx);
  end

  assign sample = hist[rd_idx];

  interp_coeff_rom #(
    .Factor      (Factor),
    .TapsPerPhase(TapsPerPhase),
    .Coeff_bits  (Coeff_bits),
    .Coeffs      (Coeffs)
  ) u_rom (
    .tap  (tap_reg),
    .phase(phase_reg),
    .coeff(coeff)
  );

  assign product     = ProdW'(sample) * ProdW'(coeff);
  assign acc_sum     = acc_reg + AccW'(product);
  assign acc_shifted = acc_sum >>> Shift;
  assign fits        = (&acc_shifted[AccW-1:Data_bits-1]) || !(|acc_shifted[AccW-1:Data_bits-1]);

  always_comb begin
    sat_data = acc_shifted[Data_bits-1:0];
    if (!fits) begin
      sat_data = acc_shifted[AccW-1] ? {1'b1, {(Data_bits-1){1'b0}}}
                                     : {1'b0, {(Data_bits-1){1'b1}}};
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = MAC;
      MAC:     if (last_tap) state_next = HOLD;
      HOLD:    if (out_fire) state_next = (phase_reg == LastPhase) ? IDLE : MAC;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg    <= '0;
      tap_reg       <= '0;
      phase_reg     <= '0;
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          acc_reg   <= '0;
          phase_reg <= '0;
          tap_reg   <= '0;
          if (accept) wr_ptr_reg <= (wr_ptr_reg == LastTap) ? '0 : wr_ptr_reg + PtrW'(1);
        end
        MAC: begin
          acc_reg <= acc_sum;
          if (last_tap) begin
            tap_reg       <= '0;
            out_data_reg  <= sat_data;
            out_valid_reg <= 1'b1;
          end else begin
            tap_reg <= tap_reg + PtrW'(1);
          end
        end
        HOLD: begin
          if (out_fire) begin
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
            if (phase_reg != LastPhase) phase_reg <= phase_reg + PhW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/interp_filter.md
# interp_filter

Polyphase interpolation FIR for the decompression/reconstruction path of the ultrasound chain. It is the receive-side counterpart of the compression-side low-pass/decimation stage. For each accepted input sample it produces `Factor` output samples (zero-stuffing and FIR in one). The filter uses one time-shared signed MAC, a circular sample history and a fixed coefficient ROM. It sits between the decompressor output and the reconstructed-RF sink, with valid/ready handshakes on both sides.

## Interface
- `Factor`, 2: upsampling ratio L (≥2); outputs per input.
- `TapsPerPhase`, 2: taps per polyphase branch P (≥1); total taps L·P.
- `Data_bits`, 10: signed sample width, in and out.
- `Coeff_bits`, 10: signed coefficient width, format Q2.(Coeff_bits-2); 1.0 = 2^(Coeff_bits-2).
- `Coeffs`, {128,256,128,0}: L·P prototype taps h[0..L·P-1]; default is linear interpolation for L=2, P=2.
- `clk_i` in 1: clock, all logic on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `in_data_i` in Data_bits: signed input sample.
- `in_valid_i` in 1: input sample valid.
- `in_ready_o` out 1: block can accept an input; high only in IDLE and never while `rst_i` is high.
- `out_data_o` out Data_bits: signed interpolated sample, registered.
- `out_valid_o` out 1: output valid, registered.
- `out_ready_i` in 1: sink accepts output.

## Operation
- States: IDLE, MAC, HOLD.
- History buffer: P entries, circular. A write pointer wraps P-1→0. Entry j back from newest is x[n-j].
- IDLE: `in_ready_o`=1; accumulator cleared; phase k=0.
  - On `in_valid_i`&&`in_ready_o`: write the sample at the write pointer, advance the pointer, go to MAC.
  - `in_valid_i` in any other state is ignored; the sample is not stored.
- MAC: P cycles, tap counter j=0..P-1.
  - Each cycle: acc += x[n-j]·h[j·L+k], signed.
  - After j=P-1: register the result into `out_data_o`, set `out_valid_o`, go to HOLD.
- HOLD: `out_valid_o` and `out_data_o` stay stable until `out_valid_o`&&`out_ready_i`.
  - On that handshake, if k<L-1: k++, clear the accumulator, go to MAC.
  - Otherwise: drop `out_valid_o`, go to IDLE.
- Arithmetic:
  - Accumulator width is Data_bits+Coeff_bits+$clog2(P+1). It never overflows.
  - Output = acc >>> (Coeff_bits-2): arithmetic shift, floor rounding.
  - The output then saturates to [-2^(Data_bits-1), 2^(Data_bits-1)-1].
- Reset (at any time, including mid-MAC or in HOLD):
  - Aborts the operation; no partial output is produced.
  - Clears the history buffer to zero and sets pointer, phase and tap counter to 0.
  - `out_valid_o`=0, `out_data_o`=0, state IDLE.

## Timing
- Input accepted at edge 0. MAC occupies cycles 1..P. `out_valid_o` rises in cycle P+1.
- With `out_ready_i` held high: each HOLD lasts 1 cycle, and the next phase's output follows P+1 cycles later.
- Minimum input period is L·(P+1)+1 cycles; `in_ready_o` rises the cycle after the last output handshake.
- `out_ready_i` low extends HOLD indefinitely. No output is lost and no new input is accepted.
- `out_ready_i` may be high before `out_valid_o`; the handshake happens in the first HOLD cycle.
- All outputs come from registers or state decode only; there is no combinational in→out path.

## Structure
- Package `interp_pkg`: `state_t` enum (IDLE, MAC, HOLD) and default coefficient constant `INTERP_COEFFS_DEFAULT`.
- Sub-module `interp_coeff_rom`: combinational lookup, parameterized by `Coeffs`, `Coeff_bits`, `Factor`, `TapsPerPhase`. Address = j·L+k.
- The history buffer, counters, MAC and FSM live in the top module.

## Test plan
- Defaults, out_ready=1. Inputs 100 then 200 → outputs 50, 100, 150, 200. Each `out_valid_o` rises 3 cycles after its phase starts.
- Input -101 after reset → outputs -51 (floor of -50.5), then -101.
- `Coeffs`={128,511,128,0}:
  - Input 511 → phase-1 output saturates to 511.
  - Input -512 → phase-1 output saturates to -512.
- Backpressure: hold `out_ready_i` low 5 cycles in HOLD. `out_valid_o` stays 1, `out_data_o` stays stable and `in_ready_o` stays 0. Releasing it yields the same data.
- Pulse `in_valid_i` with value 300 during MAC/HOLD → ignored, absent from the history. The next IDLE input 100 (prior 200) → 150, 100.
- Assert `rst_i` 1 cycle mid-MAC after input 400:
  - Next cycle: `out_valid_o`=0 and state is IDLE.
  - Then input 100 → 50, 100, showing the history was cleared.
